minisrc_control_sequencer: RTL and testbench

//  Moore control unit that sequences the Mini SRC datapath through fetch (T0-T2) and three-register ALU execute (T3-T5).

---
 rtl/minisrc_control_sequencer_pkg.sv | 33 +++
 rtl/minisrc_control_sequencer_if.sv | 28 ++
 rtl/minisrc_control_sequencer_reg_select.sv | 20 ++
 rtl/minisrc_control_sequencer.sv | 132 +++++++++++++
 tb/tb_minisrc_control_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/minisrc_control_sequencer_pkg.sv
// Shared types and constants for the Mini SRC control sequencer: state encoding,
// opcode values and instruction-register field positions.
package minisrc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [4:0] OP_REG3_LO = 5'b00011;
  localparam logic [4:0] OP_ROL     = 5'b01011;
  localparam logic [4:0] OP_REG3_HI = OP_ROL;
  localparam logic [4:0] OP_NOP     = 5'b11010;
  localparam logic [4:0] OP_HALT    = 5'b11011;

  localparam int OP_MSB    = 31;
  localparam int RA_MSB    = 26;
  localparam int RB_MSB    = 22;
  localparam int RC_MSB    = 18;
  localparam int REG_IDX_W = 4;

  function automatic logic is_reg3(input logic [4:0] op);
    return (op >= OP_REG3_LO) && (op <= OP_REG3_HI);
  endfunction

endpackage

// File: rtl/minisrc_control_sequencer_if.sv
// Datapath/memory strobe bundle between the control sequencer (master) and the
// Mini SRC datapath (slave).
interface minisrc_control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
);
  logic                PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in;
  logic                Read, MDR_in, MDR_out, IR_in, Y_in;
  logic [NUM_REGS-1:0] R_out;
  logic [NUM_REGS-1:0] R_in;
  logic [OPC_W-1:0]    alu_instruction;
  logic                mem_ready;
  logic [31:0]         IR_Data;

  modport master (
    output PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in,
    output Read, MDR_in, MDR_out, IR_in, Y_in,
    output R_out, R_in, alu_instruction,
    input  mem_ready, IR_Data
  );

  modport slave (
    input  PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in,
    input  Read, MDR_in, MDR_out, IR_in, Y_in,
    input  R_out, R_in, alu_instruction,
    output mem_ready, IR_Data
  );
endinterface

// File: rtl/minisrc_control_sequencer_reg_select.sv
// 4-bit register index to one-hot select decoder; all-zero when disabled or when
// the index is beyond NUM_REGS.
module minisrc_reg_select
  import minisrc_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                 en,
  input  logic [REG_IDX_W-1:0] sel,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (32'(sel) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/minisrc_control_sequencer.sv
// Moore control unit stepping the Mini SRC datapath through fetch (T0-T2) and a
// three-register ALU execute (T3-T5); all strobes decode from state + IR_Data.
module minisrc_control_sequencer
  import minisrc_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        run,
  minisrc_control_sequencer_if.master bus,
  output logic                        busy,
  output logic                        halted,
  output logic                        fault
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [7:0]           wait_cnt, wait_cnt_nxt;
  logic [OPC_W-1:0]     op;
  logic [REG_IDX_W-1:0] ra, rb, rc, rout_sel;
  logic                 rout_en, rin_en;
  logic                 ir_unused_bits;

  assign op = bus.IR_Data[OP_MSB -: OPC_W];
  assign ra = bus.IR_Data[RA_MSB -: REG_IDX_W];
  assign rb = bus.IR_Data[RB_MSB -: REG_IDX_W];
  assign rc = bus.IR_Data[RC_MSB -: REG_IDX_W];
  assign ir_unused_bits = ^bus.IR_Data[RC_MSB-REG_IDX_W:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    wait_cnt_nxt        = '0;
    bus.PC_out          = 1'b0;
    bus.MAR_in          = 1'b0;
    bus.IncPC           = 1'b0;
    bus.Z_in            = 1'b0;
    bus.Zlow_out        = 1'b0;
    bus.PC_in           = 1'b0;
    bus.Read            = 1'b0;
    bus.MDR_in          = 1'b0;
    bus.MDR_out         = 1'b0;
    bus.IR_in           = 1'b0;
    bus.Y_in            = 1'b0;
    bus.alu_instruction = '0;
    rout_en             = 1'b0;
    rout_sel            = rb;
    rin_en              = 1'b0;
    unique case (state)
      ST_IDLE: if (run) state_nxt = ST_T0;
      ST_T0: begin
        bus.PC_out = 1'b1;
        bus.MAR_in = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Z_in   = 1'b1;
        state_nxt  = ST_T1;
      end
      // Strobes stay up while memory is slow; re-loading PC from unchanged Z is benign.
      ST_T1: begin
        bus.Zlow_out = 1'b1;
        bus.PC_in    = 1'b1;
        bus.Read     = 1'b1;
        bus.MDR_in   = 1'b1;
        if (bus.mem_ready)                state_nxt = ST_T2;
        else if (wait_cnt == TIMEOUT_LAST) state_nxt = ST_FAULT;
        else                              wait_cnt_nxt = wait_cnt + 8'd1;
      end
      ST_T2: begin
        bus.MDR_out = 1'b1;
        bus.IR_in   = 1'b1;
        state_nxt   = ST_T3;
      end
      ST_T3: begin
        if (is_reg3(op)) begin
          rout_en    = 1'b1;
          bus.Y_in   = 1'b1;
          state_nxt  = ST_T4;
        end else if (op == OP_NOP) begin
          state_nxt = run ? ST_T0 : ST_IDLE;
        end else if (op == OP_HALT) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_FAULT;
        end
      end
      ST_T4: begin
        rout_en             = 1'b1;
        rout_sel            = rc;
        bus.alu_instruction = op;
        bus.Z_in            = 1'b1;
        state_nxt           = ST_T5;
      end
      ST_T5: begin
        bus.Zlow_out = 1'b1;
        rin_en       = 1'b1;
        state_nxt    = run ? ST_T0 : ST_IDLE;
      end
      ST_HALT, ST_FAULT: state_nxt = state;
      default: state_nxt = ST_IDLE;
    endcase
  end

  minisrc_reg_select #(.NUM_REGS(NUM_REGS)) u_rout_sel (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (bus.R_out)
  );

  minisrc_reg_select #(.NUM_REGS(NUM_REGS)) u_rin_sel (
    .en     (rin_en),
    .sel    (ra),
    .onehot (bus.R_in)
  );

  assign busy   = (state inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5});
  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_minisrc_control_sequencer.sv
// Self-checking bench for minisrc_control_sequencer: table of instructions plus
// hand-written reset, back-to-back and memory-timeout sequences.
module tb_minisrc_control_sequencer;

  localparam int MEM_TIMEOUT = 16;

  localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5,
                 S_T5 = 6, S_HALT = 7, S_FAULT = 8;
  localparam int K_ALU = 0, K_NOP = 1, K_HALT = 2, K_FAULT = 3;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in;
    logic        read, mdr_in, mdr_out, ir_in, y_in;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic [4:0]  alu;
    logic        busy, halted, fault;
  } snap_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          waits;
    int          kind;
    logic [15:0] ro3, ro4, ri5;
    logic [4:0]  alu;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  logic run;
  logic busy, halted, fault;
  int   checks = 0;
  int   failures = 0;
  snap_t exp_q[$];
  vec_t  vecs[10];

  minisrc_control_sequencer_if #(.NUM_REGS(16), .OPC_W(5)) bus ();

  minisrc_control_sequencer #(
    .NUM_REGS    (16),
    .OPC_W       (5),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .bus    (bus),
    .busy   (busy),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic snap_t es(input int st, input logic [15:0] ro,
                               input logic [15:0] ri, input logic [4:0] alu);
    snap_t s;
    s = '0;
    case (st)
      S_T0:    begin s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.z_in = 1; s.busy = 1; end
      S_T1:    begin s.zlow_out = 1; s.pc_in = 1; s.read = 1; s.mdr_in = 1; s.busy = 1; end
      S_T2:    begin s.mdr_out = 1; s.ir_in = 1; s.busy = 1; end
      S_T3:    begin s.r_out = ro; s.y_in = (ro != 16'h0); s.busy = 1; end
      S_T4:    begin s.r_out = ro; s.alu = alu; s.z_in = 1; s.busy = 1; end
      S_T5:    begin s.zlow_out = 1; s.r_in = ri; s.busy = 1; end
      S_HALT:  s.halted = 1;
      S_FAULT: s.fault = 1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic snap_t st(input int s);
    return es(s, 16'h0, 16'h0, 5'd0);
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.pc_out = bus.PC_out;   s.mar_in = bus.MAR_in;     s.inc_pc = bus.IncPC;
    s.z_in = bus.Z_in;       s.zlow_out = bus.Zlow_out; s.pc_in = bus.PC_in;
    s.read = bus.Read;       s.mdr_in = bus.MDR_in;     s.mdr_out = bus.MDR_out;
    s.ir_in = bus.IR_in;     s.y_in = bus.Y_in;
    s.r_out = bus.R_out;     s.r_in = bus.R_in;         s.alu = bus.alu_instruction;
    s.busy = busy;           s.halted = halted;         s.fault = fault;
    return s;
  endfunction

  task automatic cmp(input string nm, input snap_t got, input snap_t e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, e);
    end
  endtask

  // Drive inputs for the coming edge, queue the expected post-edge outputs, then
  // pop and compare once the outputs have settled on the falling edge.
  task automatic cyc(input logic run_v, input logic mem_v, input snap_t e, input string nm);
    snap_t x;
    run = run_v;
    bus.mem_ready = mem_v;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      x = exp_q.pop_front();
      cmp(nm, dut_snap(), x);
    end
  endtask

  task automatic do_reset(input string nm);
    clr = 1'b0;
    #1;
    cmp({nm, "_async"}, dut_snap(), st(S_IDLE));
    @(posedge clk);
    @(negedge clk);
    cmp({nm, "_held"}, dut_snap(), st(S_IDLE));
    clr = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bus.IR_Data = v.ir;
    cyc(1'b1, 1'b0, st(S_T0), {v.name, "_t0"});
    cyc(1'b0, 1'b0, st(S_T1), {v.name, "_t1"});
    for (int w = 0; w < v.waits; w++) cyc(1'b0, 1'b0, st(S_T1), {v.name, "_t1_wait"});
    cyc(1'b0, 1'b1, st(S_T2), {v.name, "_t2"});
    case (v.kind)
      K_ALU: begin
        cyc(1'b0, 1'b1, es(S_T3, v.ro3, 16'h0, 5'd0), {v.name, "_t3"});
        cyc(1'b0, 1'b1, es(S_T4, v.ro4, 16'h0, v.alu), {v.name, "_t4"});
        cyc(1'b0, 1'b1, es(S_T5, 16'h0, v.ri5, 5'd0), {v.name, "_t5"});
        cyc(1'b0, 1'b1, st(S_IDLE), {v.name, "_idle"});
        cyc(1'b0, 1'b1, st(S_IDLE), {v.name, "_idle_stay"});
      end
      K_NOP: begin
        cyc(1'b0, 1'b1, st(S_T3), {v.name, "_t3"});
        cyc(1'b0, 1'b1, st(S_IDLE), {v.name, "_idle"});
      end
      default: begin
        cyc(1'b0, 1'b1, st(S_T3), {v.name, "_t3"});
        for (int k = 0; k < 3; k++)
          cyc(1'b1, 1'b1, st(v.kind == K_HALT ? S_HALT : S_FAULT), {v.name, "_sticky"});
        do_reset({v.name, "_rst"});
      end
    endcase
  endtask

  initial begin
    clr = 1'b0;
    run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.IR_Data = 32'h0;

    vecs[0] = '{"rol_r6_r6_r4", 32'h5B32_0000, 0, K_ALU, 16'h0040, 16'h0010, 16'h0040, 5'b01011};
    vecs[1] = '{"add_r1_r2_r3_w5", mk(5'b00011, 4'd1, 4'd2, 4'd3), 5, K_ALU,
                16'h0004, 16'h0008, 16'h0002, 5'b00011};
    vecs[2] = '{"op07_r0_r15_r0_w2", mk(5'b00111, 4'd0, 4'd15, 4'd0), 2, K_ALU,
                16'h8000, 16'h0001, 16'h0001, 5'b00111};
    vecs[3] = '{"add_r1_r1_r1_w15", mk(5'b00011, 4'd1, 4'd1, 4'd1), MEM_TIMEOUT - 1, K_ALU,
                16'h0002, 16'h0002, 16'h0002, 5'b00011};
    vecs[4] = '{"op03_r15_r0_r7", mk(5'b00011, 4'd15, 4'd0, 4'd7), 0, K_ALU,
                16'h0001, 16'h0080, 16'h8000, 5'b00011};
    vecs[5] = '{"nop", mk(5'b11010, 4'd2, 4'd3, 4'd4), 0, K_NOP, 16'h0, 16'h0, 16'h0, 5'd0};
    vecs[6] = '{"halt", mk(5'b11011, 4'd3, 4'd3, 4'd3), 1, K_HALT, 16'h0, 16'h0, 16'h0, 5'd0};
    vecs[7] = '{"illegal_10101", mk(5'b10101, 4'd5, 4'd6, 4'd7), 0, K_FAULT,
                16'h0, 16'h0, 16'h0, 5'd0};
    vecs[8] = '{"below_reg3_00010", mk(5'b00010, 4'd1, 4'd2, 4'd3), 0, K_FAULT,
                16'h0, 16'h0, 16'h0, 5'd0};
    vecs[9] = '{"above_reg3_01100", mk(5'b01100, 4'd1, 4'd2, 4'd3), 0, K_FAULT,
                16'h0, 16'h0, 16'h0, 5'd0};

    @(negedge clk);
    @(negedge clk);
    cmp("reset_state", dut_snap(), st(S_IDLE));
    clr = 1'b1;
    cyc(1'b0, 1'b1, st(S_IDLE), "idle_no_run");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while in T4, then restart straight away.
    bus.IR_Data = 32'h5B32_0000;
    cyc(1'b1, 1'b1, st(S_T0), "rst_t4_t0");
    cyc(1'b1, 1'b1, st(S_T1), "rst_t4_t1");
    cyc(1'b1, 1'b1, st(S_T2), "rst_t4_t2");
    cyc(1'b1, 1'b1, es(S_T3, 16'h0040, 16'h0, 5'd0), "rst_t4_t3");
    cyc(1'b1, 1'b1, es(S_T4, 16'h0010, 16'h0, 5'b01011), "rst_t4_t4");
    do_reset("rst_in_t4");
    cyc(1'b1, 1'b1, st(S_T0), "rst_restart_t0");
    cyc(1'b0, 1'b1, st(S_T1), "rst_restart_t1");
    cyc(1'b0, 1'b1, st(S_T2), "rst_restart_t2");
    cyc(1'b0, 1'b1, es(S_T3, 16'h0040, 16'h0, 5'd0), "rst_restart_t3");
    cyc(1'b0, 1'b1, es(S_T4, 16'h0010, 16'h0, 5'b01011), "rst_restart_t4");
    cyc(1'b0, 1'b1, es(S_T5, 16'h0, 16'h0040, 5'd0), "rst_restart_t5");
    cyc(1'b0, 1'b1, st(S_IDLE), "rst_restart_idle");

    // Back-to-back: rol then add, run dropped while the second is in T3.
    bus.IR_Data = 32'h5B32_0000;
    cyc(1'b1, 1'b1, st(S_T0), "b2b_a_t0");
    cyc(1'b1, 1'b1, st(S_T1), "b2b_a_t1");
    cyc(1'b1, 1'b1, st(S_T2), "b2b_a_t2");
    cyc(1'b1, 1'b1, es(S_T3, 16'h0040, 16'h0, 5'd0), "b2b_a_t3");
    cyc(1'b1, 1'b1, es(S_T4, 16'h0010, 16'h0, 5'b01011), "b2b_a_t4");
    cyc(1'b1, 1'b1, es(S_T5, 16'h0, 16'h0040, 5'd0), "b2b_a_t5");
    bus.IR_Data = mk(5'b00100, 4'd9, 4'd10, 4'd11);
    cyc(1'b1, 1'b1, st(S_T0), "b2b_b_t0");
    cyc(1'b1, 1'b1, st(S_T1), "b2b_b_t1");
    cyc(1'b1, 1'b1, st(S_T2), "b2b_b_t2");
    cyc(1'b1, 1'b1, es(S_T3, 16'h0400, 16'h0, 5'd0), "b2b_b_t3");
    cyc(1'b0, 1'b1, es(S_T4, 16'h0800, 16'h0, 5'b00100), "b2b_b_t4");
    cyc(1'b0, 1'b1, es(S_T5, 16'h0, 16'h0200, 5'd0), "b2b_b_t5");
    cyc(1'b0, 1'b1, st(S_IDLE), "b2b_idle");

    // Memory never answers: MEM_TIMEOUT cycles in T1, then sticky FAULT.
    bus.IR_Data = 32'h5B32_0000;
    cyc(1'b1, 1'b0, st(S_T0), "tmo_t0");
    cyc(1'b0, 1'b0, st(S_T1), "tmo_t1");
    for (int w = 1; w < MEM_TIMEOUT; w++) cyc(1'b0, 1'b0, st(S_T1), "tmo_t1_wait");
    cyc(1'b0, 1'b0, st(S_FAULT), "tmo_fault");
    cyc(1'b1, 1'b1, st(S_FAULT), "tmo_sticky");
    cyc(1'b1, 1'b1, st(S_FAULT), "tmo_sticky");
    do_reset("tmo_rst");
    cyc(1'b0, 1'b1, st(S_IDLE), "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
